// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite table writer: op encodings, RAM layout, load line.
// SPRITE_WRITER_CLAMP_EN selects saturating MOVE arithmetic instead of modulo-256 wrap.
package sprite_pkg;

    typedef enum logic [1:0] {
        SPR_OP_SET_POS  = 2'd0,
        SPR_OP_SET_ATTR = 2'd1,
        SPR_OP_MOVE     = 2'd2,
        SPR_OP_CLEAR    = 2'd3
    } spr_op_e;

    localparam logic       SPR_POS_OFS   = 1'b0;
    localparam logic       SPR_ATTR_OFS  = 1'b1;
    localparam logic [8:0] SPR_LOAD_LINE = 9'd260;

    // Unsigned position plus two's-complement delta.
    function automatic logic [7:0] move_axis(input logic [7:0] pos, input logic [7:0] delta);
`ifdef SPRITE_WRITER_CLAMP_EN
        logic [9:0] sum;
        sum = {2'b00, pos} + {{2{delta[7]}}, delta};
        if (sum[9])
            return '0;
        else if (sum[8])
            return '1;
        else
            return sum[7:0];
`else
        return pos + delta;
`endif
    endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; storage is not reset.
module sprite_cmd_fifo #(
    parameter int unsigned W  = 23,
    parameter int unsigned FD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int unsigned DEPTH = 1 << FD;

    logic [W-1:0]  mem_q [DEPTH];
    logic [FD-1:0] wr_ptr_q, rd_ptr_q;
    logic [FD:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (FD+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sprite_table_writer.sv
// CPU-side sprite RAM writer: queues commands and applies them only inside the vblank grant window.
// Build option: SPRITE_WRITER_CLAMP_EN (saturating MOVE, see sprite_pkg::move_axis).
module sprite_table_writer
    import sprite_pkg::*;
#(
    parameter int unsigned NB = 5,
    parameter int unsigned FD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    vpos,
    input  logic          ram_busy,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [NB-1:0] cmd_index,
    input  logic [15:0]   cmd_data,
    output logic [NB:0]   ram_addr,
    output logic [15:0]   ram_dout,
    output logic          ram_we,
    input  logic [15:0]   ram_din,
    output logic          idle
);
    localparam int unsigned CW = 2 + NB + 16;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_MV_ADDR, S_MV_WAIT, S_MV_WB, S_CLR
    } state_e;

    state_e        state_q, state_d;
    logic [NB:0]   addr_q, addr_d;
    logic [NB:0]   cnt_q, cnt_d;
    logic [15:0]   dout_q, dout_d;
    logic [15:0]   data_q, data_d;
    logic          we_q, we_d;

    logic          grant, pop, push, fifo_full, fifo_empty;
    logic [CW-1:0] head;
    spr_op_e       head_op;
    logic [NB-1:0] head_idx;
    logic [15:0]   head_data;

    assign grant     = vpos[8] && !ram_busy && (vpos != SPR_LOAD_LINE);
    assign push      = cmd_valid && !fifo_full;
    assign head_op   = spr_op_e'(head[CW-1 -: 2]);
    assign head_idx  = head[16 +: NB];
    assign head_data = head[15:0];

    sprite_cmd_fifo #(.W(CW), .FD(FD)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cmd_op, cmd_index, cmd_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        data_d  = data_q;
        we_d    = we_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && grant) begin
                    pop    = 1'b1;
                    data_d = head_data;
                    case (head_op)
                        SPR_OP_SET_POS: begin
                            state_d = S_WR;
                            addr_d  = {head_idx, SPR_POS_OFS};
                            dout_d  = head_data;
                            we_d    = 1'b1;
                        end
                        SPR_OP_SET_ATTR: begin
                            state_d = S_WR;
                            addr_d  = {head_idx, SPR_ATTR_OFS};
                            dout_d  = head_data;
                            we_d    = 1'b1;
                        end
                        SPR_OP_MOVE: begin
                            state_d = S_MV_ADDR;
                            addr_d  = {head_idx, SPR_POS_OFS};
                            we_d    = 1'b0;
                        end
                        default: begin
                            state_d = S_CLR;
                            cnt_d   = '0;
                            addr_d  = '0;
                            dout_d  = '0;
                            we_d    = 1'b1;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (grant) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                end
            end
            S_MV_ADDR: begin
                if (grant) state_d = S_MV_WAIT;
            end
            // Any grant loss after the read restarts the MOVE so the read is repeated.
            S_MV_WAIT: begin
                if (grant) begin
                    dout_d  = {move_axis(ram_din[15:8], data_q[15:8]),
                               move_axis(ram_din[7:0],  data_q[7:0])};
                    we_d    = 1'b1;
                    state_d = S_MV_WB;
                end else begin
                    state_d = S_MV_ADDR;
                end
            end
            S_MV_WB: begin
                we_d    = 1'b0;
                state_d = grant ? S_IDLE : S_MV_ADDR;
            end
            S_CLR: begin
                if (grant) begin
                    if (cnt_q == '1) begin
                        state_d = S_IDLE;
                        we_d    = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    // The strobe is qualified by grant so a pending write stalls the same cycle the window closes.
    assign ram_we    = we_q && grant;
    assign ram_addr  = addr_q;
    assign ram_dout  = dout_q;
    assign cmd_ready = !fifo_full;
    assign idle      = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_sprite_table_writer.sv
// Directed bench for sprite_table_writer with a 1-cycle-latency RAM model.
module tb_sprite_table_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  vpos;
    logic        ram_busy;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_index;
    logic [15:0] cmd_data;
    logic [5:0]  ram_addr;
    logic [15:0] ram_dout;
    logic        ram_we;
    logic [15:0] ram_din;
    logic        idle;

    logic [15:0] mem [64];
    logic        pre_we, pre_fill;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;

    int total = 0;
    int bad = 0;
    int we_count = 0;
    int viol = 0;
    logic [21:0] wlog [$];

    always #5 clk = ~clk;

    sprite_table_writer #(.NB(5), .FD(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .vpos      (vpos),
        .ram_busy  (ram_busy),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_index (cmd_index),
        .cmd_data  (cmd_data),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .idle      (idle)
    );

    always @(posedge clk) begin
        if (pre_fill)
            for (int i = 0; i < 64; i++) mem[i] <= 16'hA500 | 16'(i);
        else if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_we)
            mem[ram_addr] <= ram_dout;
        ram_din <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_count++;
            wlog.push_back({ram_addr, ram_dout});
            if (!(vpos[8] && !ram_busy && vpos != 9'd260)) viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [4:0] idx, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_index = idx;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (idle !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        int c0, c1, nz, order_bad;
        logic [15:0] exp_clamp;

        reset = 1'b1; vpos = 9'd0; ram_busy = 1'b0; cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_index = 5'd0; cmd_data = 16'h0;
        pre_we = 1'b0; pre_fill = 1'b0; pre_addr = 6'd0; pre_data = 16'h0;
        #1;
        check("rst_addr",  32'(ram_addr),  32'h0);
        check("rst_dout",  32'(ram_dout),  32'h0);
        check("rst_we",    32'(ram_we),    32'h0);
        check("rst_idle",  32'(idle),      32'h1);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        pre_fill = 1'b1;
        tick();
        pre_fill = 1'b0;
        tick();
        reset = 1'b0;

        // SET_POS queued outside vblank, applied at line 256
        vpos = 9'd100;
        push(2'd0, 5'd3, 16'h4020);
        check("t1_busy", 32'(idle), 32'h0);
        repeat (5) tick();
        check("t1_nowrite", 32'(we_count), 32'd0);
        check("t1_word_old", 32'(mem[6]), 32'hA506);
        vpos = 9'd256;
        tick();
        check("t1_we", 32'(ram_we), 32'h1);
        check("t1_addr", 32'(ram_addr), 32'd6);
        check("t1_dout", 32'(ram_dout), 32'h4020);
        tick();
        check("t1_word", 32'(mem[6]), 32'h4020);
        check("t1_we_off", 32'(ram_we), 32'h0);
        check("t1_idle", 32'(idle), 32'h1);
        check("t1_count", 32'(we_count), 32'd1);

        // MOVE with negative dy
        preload(6'd10, 16'h1008);
        vpos = 9'd257;
        c0 = we_count;
        push(2'd2, 5'd5, 16'hFF02);
        tick();
        check("t2_rd_we", 32'(ram_we), 32'h0);
        check("t2_rd_addr", 32'(ram_addr), 32'd10);
        tick();
        check("t2_wait_we", 32'(ram_we), 32'h0);
        tick();
        check("t2_wb_we", 32'(ram_we), 32'h1);
        check("t2_wb_dout", 32'(ram_dout), 32'h0F0A);
        tick();
        check("t2_word", 32'(mem[10]), 32'h0F0A);
        check("t2_one_write", 32'(we_count - c0), 32'd1);
        check("t2_we_off", 32'(ram_we), 32'h0);

        // MOVE overflowing x
        preload(6'd0, 16'h00FF);
        push(2'd2, 5'd0, 16'h0001);
        wait_idle(20, "t3_idle");
`ifdef SPRITE_WRITER_CLAMP_EN
        exp_clamp = 16'h00FF;
`else
        exp_clamp = 16'h0000;
`endif
        check("t3_word", 32'(mem[0]), 32'(exp_clamp));

        // FIFO fills while stalled, drains in order
        vpos = 9'd10;
        wlog.delete();
        c0 = we_count;
        push(2'd0, 5'd1, 16'h1111);
        push(2'd1, 5'd1, 16'h2222);
        push(2'd0, 5'd2, 16'h3333);
        check("t4_ready3", 32'(cmd_ready), 32'h1);
        push(2'd1, 5'd2, 16'h4444);
        check("t4_ready4", 32'(cmd_ready), 32'h0);
        push(2'd0, 5'd7, 16'h7777);
        check("t4_ready5", 32'(cmd_ready), 32'h0);
        check("t4_stalled", 32'(we_count - c0), 32'd0);
        vpos = 9'd256;
        wait_idle(40, "t4_idle");
        check("t4_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            check("t4_w0", 32'(wlog[0]), 32'({6'd2, 16'h1111}));
            check("t4_w1", 32'(wlog[1]), 32'({6'd3, 16'h2222}));
            check("t4_w2", 32'(wlog[2]), 32'({6'd4, 16'h3333}));
            check("t4_w3", 32'(wlog[3]), 32'({6'd5, 16'h4444}));
        end
        check("t4_dropped", 32'(mem[14]), 32'hA50E);

        // CLEAR_ALL pausing over line 260
        vpos = 9'd259;
        wlog.delete();
        c0 = we_count;
        push(2'd3, 5'd0, 16'h0);
        repeat (10) tick();
        vpos = 9'd260;
        #1;
        c1 = we_count;
        check("t5_started", 32'(c1 > c0), 32'd1);
        check("t5_we_260", 32'(ram_we), 32'h0);
        repeat (5) tick();
        check("t5_pause", 32'(we_count), 32'(c1));
        check("t5_busy", 32'(idle), 32'h0);
        vpos = 9'd261;
        wait_idle(100, "t5_idle");
        check("t5_total", 32'(we_count - c0), 32'd64);
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 16'h0) nz++;
        check("t5_zeroed", 32'(nz), 32'd0);
        order_bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {6'(i), 16'h0}) order_bad++;
        check("t5_order", 32'(order_bad), 32'd0);

        // Reset during MV_WAIT
        preload(6'd20, 16'h1234);
        vpos = 9'd257;
        c0 = we_count;
        push(2'd2, 5'd10, 16'h0101);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_we", 32'(ram_we), 32'h0);
        check("t6_idle", 32'(idle), 32'h1);
        check("t6_ready", 32'(cmd_ready), 32'h1);
        check("t6_addr", 32'(ram_addr), 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t6_word", 32'(mem[20]), 32'h1234);
        check("t6_nowrite", 32'(we_count - c0), 32'd0);

        check("grant_guard", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
